// File: rtl/dct_pkg.sv
// Shared DCT pipeline definitions.
// Holds the block dimension, coefficient width and the state enums used by
// the transpose buffer, the DCT stages and the quantizer.
// No ports (package).
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int COEF_W = 12;

  // Life cycle of one transpose bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  // Column read-out sequencer.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // A bank holding an unread or in-flight block must not take new rows.
  function automatic logic bank_unwritable(input bank_state_e st);
    return (st == FULL) || (st == READING);
  endfunction

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out bus of the DCT transpose buffer.
// Signals:
//   i_valid, i_data0..7   row strobe and row elements (column index 0..7)
//   o_ready               a row can be accepted this cycle
//   o_valid, o_data0..7   column strobe and column elements (row index 0..7)
//   o_col_idx, o_last     index of the column on o_data*, high on column 7
//   o_overflow            sticky: a row was offered while o_ready was low
// Modports: master = upstream producer / downstream consumer side,
//           slave  = the transpose buffer itself.
interface dct_transpose_buffer_if #(
  parameter int DATA_W = dct_pkg::COEF_W
);

  logic                     i_valid;
  logic signed [DATA_W-1:0] i_data0, i_data1, i_data2, i_data3;
  logic signed [DATA_W-1:0] i_data4, i_data5, i_data6, i_data7;
  logic                     o_ready;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_data0, o_data1, o_data2, o_data3;
  logic signed [DATA_W-1:0] o_data4, o_data5, o_data6, o_data7;
  logic [2:0]               o_col_idx;
  logic                     o_last;
  logic                     o_overflow;

  modport master (
    output i_valid,
    output i_data0, i_data1, i_data2, i_data3,
    output i_data4, i_data5, i_data6, i_data7,
    input  o_ready, o_valid,
    input  o_data0, o_data1, o_data2, o_data3,
    input  o_data4, o_data5, o_data6, o_data7,
    input  o_col_idx, o_last, o_overflow
  );

  modport slave (
    input  i_valid,
    input  i_data0, i_data1, i_data2, i_data3,
    input  i_data4, i_data5, i_data6, i_data7,
    output o_ready, o_valid,
    output o_data0, o_data1, o_data2, o_data3,
    output o_data4, o_data5, o_data6, o_data7,
    output o_col_idx, o_last, o_overflow
  );

endinterface

// File: rtl/dct_transpose_bank.sv
// One N x N coefficient store of the transpose buffer.
// A full row is written per cycle; a full column is read combinationally.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   we              write enable for the row at wr_row
//   wr_row          row address (0..N-1)
//   wr_data[c]      element for column c of that row
//   rd_col          column address (0..N-1)
//   rd_data[r]      element at row r of column rd_col
module dct_transpose_bank #(
  parameter int DATA_W = 12,
  parameter int N      = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     we,
  input  logic [2:0]               wr_row,
  input  logic signed [DATA_W-1:0] wr_data [N],
  input  logic [2:0]               rd_col,
  output logic signed [DATA_W-1:0] rd_data [N]
);

  logic signed [DATA_W-1:0] mem_r [N][N];

  // Row write port; cleared on reset so no block survives a reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_r[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else if (we) begin
      for (int c = 0; c < N; c++) begin
        mem_r[wr_row][c] <= wr_data[c];
      end
    end else begin
      mem_r <= mem_r;
    end
  end

  // Column read port: element r comes from row r.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      rd_data[r] = mem_r[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Row-to-column transpose buffer between the two 1D-DCT passes.
// Collects eight rows of a block, then emits its eight columns as one
// contiguous burst; coefficients pass through unchanged.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   bus             dct_transpose_buffer_if.slave (row in, column out)
// Configuration macro DCT_TRANSPOSE_PINGPONG_EN:
//   defined   -> two banks, writes alternate, filling overlaps read-out
//   undefined -> one bank, o_ready low while the block is being read out
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DATA_W = COEF_W,
  parameter int N      = DCT_N
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  dct_transpose_buffer_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  logic signed [DATA_W-1:0] row_data_s  [N];
  logic signed [DATA_W-1:0] col_data_s  [N];
  logic signed [DATA_W-1:0] bank0_col_s [N];

  bank_state_e bank_st_r     [2];
  bank_state_e bank_st_nxt_s [2];
  rd_state_e   rd_state_r, rd_state_nxt_s;

  logic [2:0] wr_row_r, wr_row_nxt_s;
  logic [2:0] rd_col_r, rd_col_nxt_s;
  logic       wr_bank_r, wr_bank_nxt_s;
  logic       rd_bank_r, rd_bank_nxt_s;
  logic       accept_s;
  logic       load_s;
  logic [2:0] load_col_s;
  logic       ready_r, ready_nxt_s;
  logic       overflow_r, overflow_nxt_s;

  logic                     valid_r;
  logic                     last_r;
  logic [2:0]               col_idx_r;
  logic signed [DATA_W-1:0] data_r [N];

  assign row_data_s[0] = bus.i_data0;
  assign row_data_s[1] = bus.i_data1;
  assign row_data_s[2] = bus.i_data2;
  assign row_data_s[3] = bus.i_data3;
  assign row_data_s[4] = bus.i_data4;
  assign row_data_s[5] = bus.i_data5;
  assign row_data_s[6] = bus.i_data6;
  assign row_data_s[7] = bus.i_data7;

`ifdef DCT_TRANSPOSE_PINGPONG_EN
  logic signed [DATA_W-1:0] bank1_col_s [N];

  dct_transpose_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .we      (accept_s && !wr_bank_r),
    .wr_row  (wr_row_r),
    .wr_data (row_data_s),
    .rd_col  (load_col_s),
    .rd_data (bank0_col_s)
  );

  dct_transpose_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .we      (accept_s && wr_bank_r),
    .wr_row  (wr_row_r),
    .wr_data (row_data_s),
    .rd_col  (load_col_s),
    .rd_data (bank1_col_s)
  );

  // The column being loaded always belongs to the bank the reader moves to.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      col_data_s[r] = rd_bank_nxt_s ? bank1_col_s[r] : bank0_col_s[r];
    end
  end
`else
  dct_transpose_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .we      (accept_s),
    .wr_row  (wr_row_r),
    .wr_data (row_data_s),
    .rd_col  (load_col_s),
    .rd_data (bank0_col_s)
  );

  // Single bank: the column always comes from bank 0.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      col_data_s[r] = bank0_col_s[r];
    end
  end
`endif

  // Next-state logic: read sequencer first, then the write side.  The two
  // sides never touch the same bank in one cycle, except when a new row 0
  // lands in a bank whose last column is leaving; the write then wins.
  always_comb begin
    bank_st_nxt_s  = bank_st_r;
    rd_state_nxt_s = rd_state_r;
    rd_col_nxt_s   = rd_col_r;
    rd_bank_nxt_s  = rd_bank_r;
    wr_row_nxt_s   = wr_row_r;
    wr_bank_nxt_s  = wr_bank_r;
    load_s         = 1'b0;
    load_col_s     = 3'd0;
    accept_s       = bus.i_valid && ready_r;

    case (rd_state_r)
      IDLE: begin
        if (bank_st_r[rd_bank_r] == FULL) begin
          rd_state_nxt_s           = READ;
          rd_col_nxt_s             = 3'd0;
          bank_st_nxt_s[rd_bank_r] = READING;
          load_s                   = 1'b1;
          load_col_s               = 3'd0;
        end else begin
          rd_state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (rd_col_r != LAST_IDX) begin
          rd_col_nxt_s = rd_col_r + 3'd1;
          load_s       = 1'b1;
          load_col_s   = rd_col_r + 3'd1;
        end else begin
          bank_st_nxt_s[rd_bank_r] = EMPTY;
          rd_col_nxt_s             = 3'd0;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
          // Banks fill in alternation, so the next block is in the other one.
          rd_bank_nxt_s = ~rd_bank_r;
          if (bank_st_r[~rd_bank_r] == FULL) begin
            bank_st_nxt_s[~rd_bank_r] = READING;
            load_s                    = 1'b1;
            load_col_s                = 3'd0;
          end else begin
            rd_state_nxt_s = IDLE;
          end
`else
          rd_state_nxt_s = IDLE;
`endif
        end
      end
      default: begin
        rd_state_nxt_s = IDLE;
      end
    endcase

    if (accept_s) begin
      if (wr_row_r == LAST_IDX) begin
        bank_st_nxt_s[wr_bank_r] = FULL;
        wr_row_nxt_s             = 3'd0;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
        wr_bank_nxt_s = ~wr_bank_r;
`else
        wr_bank_nxt_s = 1'b0;
`endif
      end else begin
        bank_st_nxt_s[wr_bank_r] = FILLING;
        wr_row_nxt_s             = wr_row_r + 3'd1;
      end
    end else begin
      wr_row_nxt_s = wr_row_r;
    end

    overflow_nxt_s = overflow_r | (bus.i_valid & ~ready_r);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    // Once the last column of the write bank sits in the output registers
    // the bank holds nothing unread, so the next row may overwrite it.
    if ((bank_st_nxt_s[wr_bank_nxt_s] == READING) && (rd_state_nxt_s == READ) &&
        (rd_bank_nxt_s == wr_bank_nxt_s) && (rd_col_nxt_s == LAST_IDX)) begin
      ready_nxt_s = 1'b1;
    end else begin
      ready_nxt_s = !bank_unwritable(bank_st_nxt_s[wr_bank_nxt_s]);
    end
`else
    ready_nxt_s = !bank_unwritable(bank_st_nxt_s[wr_bank_nxt_s]);
`endif
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_r[b] <= EMPTY;
      end
      rd_state_r <= IDLE;
      rd_col_r   <= 3'd0;
      rd_bank_r  <= 1'b0;
      wr_row_r   <= 3'd0;
      wr_bank_r  <= 1'b0;
      ready_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      bank_st_r  <= bank_st_nxt_s;
      rd_state_r <= rd_state_nxt_s;
      rd_col_r   <= rd_col_nxt_s;
      rd_bank_r  <= rd_bank_nxt_s;
      wr_row_r   <= wr_row_nxt_s;
      wr_bank_r  <= wr_bank_nxt_s;
      ready_r    <= ready_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // Output column registers; zero whenever no column is being presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      col_idx_r <= 3'd0;
      for (int r = 0; r < N; r++) begin
        data_r[r] <= {DATA_W{1'b0}};
      end
    end else begin
      valid_r   <= load_s;
      last_r    <= load_s && (load_col_s == LAST_IDX);
      col_idx_r <= load_s ? load_col_s : 3'd0;
      for (int r = 0; r < N; r++) begin
        data_r[r] <= load_s ? col_data_s[r] : {DATA_W{1'b0}};
      end
    end
  end

  assign bus.o_ready    = ready_r;
  assign bus.o_overflow = overflow_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_last     = last_r;
  assign bus.o_col_idx  = col_idx_r;
  assign bus.o_data0    = data_r[0];
  assign bus.o_data1    = data_r[1];
  assign bus.o_data2    = data_r[2];
  assign bus.o_data3    = data_r[3];
  assign bus.o_data4    = data_r[4];
  assign bus.o_data5    = data_r[5];
  assign bus.o_data6    = data_r[6];
  assign bus.o_data7    = data_r[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer.
// A block-level reference model (row counting, a burst schedule of expected
// columns and a ready window) predicts every output each cycle.
module tb_dct_transpose_buffer;
  import dct_pkg::*;

  localparam int W  = COEF_W;
  localparam int RW = 8 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dct_transpose_buffer_if #(.DATA_W(W)) bus ();

  dct_transpose_buffer #(.DATA_W(W), .N(DCT_N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state.
  int            q_cyc [$];
  int            q_col [$];
  logic [RW-1:0] q_dat [$];
  logic [W-1:0]  blk [8][8];
  int            m_rows;
  int            m_out_next;
  int            blk_lo;
  int            blk_hi;
  logic          m_ready;
  logic          m_ovf;
  logic          m_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic signed [W-1:0] out_data(input int r);
    case (r)
      0: return bus.o_data0;
      1: return bus.o_data1;
      2: return bus.o_data2;
      3: return bus.o_data3;
      4: return bus.o_data4;
      5: return bus.o_data5;
      6: return bus.o_data6;
      7: return bus.o_data7;
      default: return '0;
    endcase
  endfunction

  function automatic logic [RW-1:0] mk_row(input int r, input int base);
    logic [RW-1:0] row;
    for (int c = 0; c < 8; c++) row[c*W +: W] = W'(16 * r + c + base);
    return row;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] row;
    for (int c = 0; c < 8; c++) row[c*W +: W] = W'($urandom);
    return row;
  endfunction

  function automatic logic [RW-1:0] extreme_row(input int r, input bit rnd);
    logic [RW-1:0] row;
    for (int c = 0; c < 8; c++) begin
      if (rnd ? ($urandom_range(0, 1) == 1) : (((r + c) % 2) == 1))
        row[c*W +: W] = W'(2047);
      else
        row[c*W +: W] = W'(-2048);
    end
    return row;
  endfunction

  task automatic drive(input logic v, input logic [RW-1:0] row);
    bus.i_valid = v;
    bus.i_data0 = row[0*W +: W];
    bus.i_data1 = row[1*W +: W];
    bus.i_data2 = row[2*W +: W];
    bus.i_data3 = row[3*W +: W];
    bus.i_data4 = row[4*W +: W];
    bus.i_data5 = row[5*W +: W];
    bus.i_data6 = row[6*W +: W];
    bus.i_data7 = row[7*W +: W];
  endtask

  // Effect of clock edge number cyc on the model; m_ready is the ready
  // value that was visible while the sampled row was presented.
  task automatic model_edge(input logic v, input logic [RW-1:0] row);
    logic [RW-1:0] col;
    int start;
    if (m_rst) begin
      m_ready = 1'b0;
    end else begin
      if (v && !m_ready) m_ovf = 1'b1;
      if (v && m_ready) begin
        for (int c = 0; c < 8; c++) blk[m_rows][c] = row[c*W +: W];
        m_rows++;
        if (m_rows == 8) begin
          m_rows = 0;
          start = (cyc + 1 > m_out_next) ? cyc + 1 : m_out_next;
          for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) col[r*W +: W] = blk[r][c];
            q_cyc.push_back(start + c);
            q_col.push_back(c);
            q_dat.push_back(col);
          end
          m_out_next = start + 8;
`ifndef DCT_TRANSPOSE_PINGPONG_EN
          blk_lo = cyc;
          blk_hi = cyc + 8;
`endif
        end
      end
      m_ready = !(cyc >= blk_lo && cyc <= blk_hi);
    end
  endtask

  task automatic check_cycle();
    logic [RW-1:0] d;
    if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
      d = q_dat[0];
      chk("valid", 32'(bus.o_valid), 32'd1);
      chk("col_idx", 32'(bus.o_col_idx), 32'(q_col[0]));
      chk("last", 32'(bus.o_last), (q_col[0] == 7) ? 32'd1 : 32'd0);
      for (int r = 0; r < 8; r++) chk($sformatf("data%0d", r), out_data(r), $signed(d[r*W +: W]));
      void'(q_cyc.pop_front());
      void'(q_col.pop_front());
      void'(q_dat.pop_front());
    end else begin
      chk("idle_valid", 32'(bus.o_valid), 32'd0);
      chk("idle_last", 32'(bus.o_last), 32'd0);
    end
    chk("ready", 32'(bus.o_ready), 32'(m_ready));
    chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic v, input logic [RW-1:0] row);
    drive(v, row);
    @(posedge clk);
    cyc++;
    model_edge(v, row);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // Asserts reset away from any clock edge and checks the outputs fall at once.
  task automatic do_reset(input int n);
    drive(1'b0, '0);
    rst_n = 1'b0;
    #1;
    m_rst = 1'b1;
    m_rows = 0;
    m_ovf = 1'b0;
    m_ready = 1'b0;
    m_out_next = 0;
    blk_lo = -100;
    blk_hi = -100;
    q_cyc.delete();
    q_col.delete();
    q_dat.delete();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_last", 32'(bus.o_last), 32'd0);
    chk("rst_col_idx", 32'(bus.o_col_idx), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_overflow", 32'(bus.o_overflow), 32'd0);
    for (int r = 0; r < 8; r++) chk($sformatf("rst_data%0d", r), out_data(r), 32'd0);
    idle(n);
    rst_n = 1'b1;
    m_rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0);
    @(negedge clk);

    // Reset for three cycles, then the first edge after release.
    do_reset(3);
    idle(1);
    for (int r = 0; r < 8; r++) chk($sformatf("post_rst_data%0d", r), out_data(r), 32'd0);

    // Transpose of one block of consecutive rows.
    for (int r = 0; r < 8; r++) step(1'b1, mk_row(r, 0));
    idle(12);

    // Upstream cadence: one row every eight cycles, two blocks.
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) begin
        step(1'b1, mk_row(r, 256 * b));
        idle(7);
      end
`ifndef DCT_TRANSPOSE_PINGPONG_EN
      idle(2);
`endif
    end
    idle(12);

    // Back-to-back: sixteen rows on consecutive cycles.
    for (int i = 0; i < 16; i++) step(1'b1, rand_row());
    idle(20);

    // Extreme coefficient values, fixed pattern then random mix.
    for (int r = 0; r < 8; r++) step(1'b1, extreme_row(r, 1'b0));
    idle(10);
    for (int r = 0; r < 8; r++) step(1'b1, extreme_row(r, 1'b1));
    idle(12);

    // Random data with random row spacing.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, rand_row());
      idle($urandom_range(0, 2));
    end
    idle(20);

    // Burst abort: reset three columns into a burst.
    for (int r = 0; r < 8; r++) step(1'b1, mk_row(r, 512));
    idle(3);
    do_reset(2);
    idle(2);

    // Reset mid-fill, then a block of sevens with no stale data.
    for (int r = 0; r < 5; r++) step(1'b1, mk_row(r, 1024));
    do_reset(3);
    idle(1);
    for (int r = 0; r < 8; r++) step(1'b1, {8{W'(7)}});
    idle(12);

    chk("pending_columns", 32'(q_cyc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
